// File: rtl/abm_ram_loader.sv
// Write-side loader for one ABM bitmap RAM bank: on start it zero-fills the
// bank, then streams one AXI4-Stream packet into it row by row from address 0.
module abm_ram_loader #(
    parameter int DW = 512,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    output logic          busy,
    output logic          overflow,
    output logic [AW:0]   rows_written,
    input  logic [DW-1:0] AXIS_RX_TDATA,
    input  logic          AXIS_RX_TVALID,
    input  logic          AXIS_RX_TLAST,
    output logic          AXIS_RX_TREADY,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata
);

    // Stream handshake: a beat transfers on a cycle where TVALID and TREADY are
    // both high. TREADY is held high for the whole LOAD state (no back-pressure).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [AW:0]   FULL      = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          busy_d, ovf_d, tready_d, we_d;
    logic [AW-1:0] waddr_d;
    logic [DW-1:0] wdata_d;
    logic          hs;

    assign hs           = AXIS_RX_TVALID & AXIS_RX_TREADY;
    // The row pointer only advances on written rows, so it is also the count.
    assign rows_written = ptr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            busy           <= 1'b0;
            overflow       <= 1'b0;
            AXIS_RX_TREADY <= 1'b0;
            ram_we         <= 1'b0;
            ram_waddr      <= '0;
            ram_wdata      <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            busy           <= busy_d;
            overflow       <= ovf_d;
            AXIS_RX_TREADY <= tready_d;
            ram_we         <= we_d;
            ram_waddr      <= waddr_d;
            ram_wdata      <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy;
        ovf_d    = overflow;
        tready_d = AXIS_RX_TREADY;
        we_d     = 1'b0;
        waddr_d  = ram_waddr;
        wdata_d  = ram_wdata;
        case (state_q)
            IDLE: begin
                tready_d = 1'b0;
                if (start) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    ptr_d   = '0;
                    waddr_d = '0;
                    wdata_d = '0;
                    we_d    = 1'b1;
                end
            end
            CLEAR: begin
                // ram_waddr is the row being zeroed this cycle.
                we_d    = 1'b1;
                wdata_d = '0;
                if (ram_waddr == LAST_ADDR) begin
                    state_d  = LOAD;
                    tready_d = 1'b1;
                    we_d     = 1'b0;
                    ptr_d    = '0;
                end else begin
                    waddr_d = ram_waddr + 1'b1;
                end
            end
            LOAD: begin
                tready_d = 1'b1;
                if (hs) begin
                    if (ptr_q < FULL) begin
                        we_d    = 1'b1;
                        waddr_d = ptr_q[AW-1:0];
                        wdata_d = AXIS_RX_TDATA;
                        ptr_d   = ptr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (AXIS_RX_TLAST) begin
                        state_d  = IDLE;
                        tready_d = 1'b0;
                        busy_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/abm_ram_loader.md
# abm_ram_loader

Upstream write-side stage for one bank of the ABM bitmap RAM pair. On a start pulse it zero-fills its SDP RAM bank, then streams an AXI4-Stream packet into the bank row by row from address 0, one DW-bit row per beat. Two instances, one per bank, feed the write ports of the RAMs whose read ports are merged by the AXI read-only interface downstream.

## Interface
- DW, 512: RAM row width and stream data width, in bits.
- AW, 14: RAM address width. The bank depth is 2^AW rows.

- clk  in  1  Sole clock.
- resetn  in  1  Reset. Asynchronous, active-low.
- start  in  1  Single-cycle pulse that begins a clear-then-load sequence. Ignored while busy=1.
- busy  out  1  High from the cycle after an accepted start until the load completes.
- overflow  out  1  Sticky flag. Set when a packet carries more than 2^AW beats. Cleared by an accepted start.
- rows_written  out  AW+1  Number of stream rows written since the last start. Saturates at 2^AW.
- AXIS_RX_TDATA  in  DW  Row data.
- AXIS_RX_TVALID  in  1  Source has a valid beat.
- AXIS_RX_TLAST  in  1  Marks the final beat of the packet.
- AXIS_RX_TREADY  out  1  Loader accepts a beat.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  DW  RAM write data.

## Operation
- Reset values: busy=0, overflow=0, rows_written=0, AXIS_RX_TREADY=0, ram_we=0, ram_waddr=0, ram_wdata=0. FSM enters IDLE.
- Reset asserted mid-sequence aborts immediately and returns all outputs to the reset values. Partially written RAM contents are left as they are.

State machine:
- IDLE
  - TREADY=0, ram_we=0.
  - start=1 → CLEAR. Set busy=1, overflow=0, rows_written=0, ram_waddr=0, ram_wdata=0, ram_we=1.
- CLEAR
  - One zero row is written per cycle; ram_waddr increments each cycle.
  - When ram_waddr = 2^AW−1 is written → LOAD. Set TREADY=1, ram_we=0, internal row pointer=0.
- LOAD
  - TREADY is held at 1 for the whole state; there is no back-pressure.
  - On each handshake (TVALID & TREADY), if the row pointer is below 2^AW:
    - ram_wdata←TDATA, ram_waddr←pointer, ram_we=1 on the next cycle.
    - Row pointer and rows_written each increment.
  - A handshake with the pointer already at 2^AW is discarded: ram_we=0, overflow←1.
  - A cycle with no handshake gives ram_we=0 on the next cycle.
  - A handshake with TLAST=1 (written or discarded) → IDLE. TREADY drops on the next cycle and busy drops on that same cycle.
- start received in CLEAR or LOAD has no effect.
- A packet shorter than 2^AW beats leaves the remaining rows at zero.
- rows_written width is AW+1 so it can represent the full count 2^AW.
- Address arithmetic is modulo 2^AW. The pointer is AW+1 bits wide so the full condition can be detected.

## Timing
- start → busy=1 and the first clear write (ram_we=1, addr 0): 1 cycle.
- The clear phase lasts exactly 2^AW cycles with ram_we=1 continuously.
- TREADY rises the cycle after the last clear write.
- The first clear write is at cycle t+1 after start at t. TREADY=1 from cycle t+1+2^AW.
- Beat accepted at cycle n → ram_we/ram_waddr/ram_wdata valid at cycle n+1. RAM write latency is 1 cycle.
- Back-to-back beats produce back-to-back writes; throughput is 1 row per clock.
- TLAST accepted at cycle n:
  - the last row is written at n+1;
  - TREADY=0 and busy=0 at n+1.
- The downstream reader sees the row written at n+1 from cycle n+2 onward; the SDP RAM write-to-read latency is 1.
- A new start is honoured from the first cycle busy=0.

## Test plan
- AW=4, DW=32. Pulse start with RAM preloaded with 0xFFFFFFFF → 16 consecutive zero writes to addr 0..15, then TREADY=1 on cycle 17, busy=1 throughout.
- After clear, send 3 beats 0xA, 0xB, 0xC (TLAST on 0xC) with TVALID held high → writes addr 0..2 with those values on consecutive cycles; rows_written=3; busy and TREADY fall the cycle after the 0xC handshake.
- Same packet with TVALID toggling 1/0 → writes occur only the cycle after each handshake; addresses remain contiguous 0,1,2.
- Send 18 beats (TLAST on beat 18) → 16 writes to addr 0..15; beats 17–18 discarded; overflow=1; rows_written=16; next start clears overflow to 0.
- Assert start while busy in CLEAR and while busy in LOAD → no restart; the clear count stays 16; load addresses are uninterrupted.
- Drop resetn asynchronously at clear address 7 → all outputs return to reset values without waiting for a clock edge. After release, start begins a fresh clear at addr 0.
